// File: rtl/sw_out_arb.sv
// sw_out_arb: round-robin scheduler popping one FIFO word per cycle into a valid/ready output register.
// Optional SW_ARB_CNT_EN adds saturating per-input grant counters with a synchronous clear.
`ifndef PKTW
`define PKTW 31
`endif
module sw_out_arb #(
   parameter int NIN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NIN-1:0]             fifo_empty,
   input  logic [NIN*(`PKTW+1)-1:0]   fifo_out,
   output logic [NIN-1:0]             fifo_re,
   output logic [`PKTW:0]             out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NIN-1:0]             grant
`ifdef SW_ARB_CNT_EN
   ,
   input  logic                       cnt_clr,
   output logic [NIN*16-1:0]          grant_cnt
`endif
);
   localparam int W  = `PKTW + 1;
   localparam int LW = $clog2(NIN);
   logic [LW-1:0] last;
   logic [LW-1:0] sel;
   logic          hit;
   logic          free;
   logic          pop;
   int            idx;
   assign free = !out_valid || out_ready;
   // first non-empty FIFO after the previous winner, modulo NIN
   always_comb begin
      hit = 1'b0;
      sel = '0;
      idx = 0;
      for (int k = 1; k <= NIN; k++) begin
         idx = (int'(last) + k) % NIN;
         if (!hit && !fifo_empty[idx]) begin
            hit = 1'b1;
            sel = LW'(idx);
         end
      end
   end
   assign fifo_re = (rst && free && hit) ? ({{(NIN-1){1'b0}}, 1'b1} << sel) : '0;
   assign pop     = |fifo_re;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         grant     <= '0;
         last      <= LW'(NIN - 1);
      end else if (pop) begin
         out_data  <= fifo_out[int'(sel)*W +: W];
         out_valid <= 1'b1;
         grant     <= fifo_re;
         last      <= sel;
      end else if (free) begin
         out_valid <= 1'b0;
      end
   end
`ifdef SW_ARB_CNT_EN
   logic [15:0] cnt [NIN];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NIN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NIN; i++)
            cnt[i] <= cnt_clr ? 16'd0 : (fifo_re[i] && cnt[i] != 16'hFFFF) ? cnt[i] + 16'd1 : cnt[i];
      end
   end
   for (genvar g = 0; g < NIN; g++) begin : g_cnt
      assign grant_cnt[g*16 +: 16] = cnt[g];
   end
`endif
endmodule

// File: tb/tb_sw_out_arb.sv
// tb_sw_out_arb: directed scenarios for sw_out_arb against a queue model of first-word fall-through FIFOs.
`ifndef PKTW
`define PKTW 31
`endif
module tb_sw_out_arb;
   localparam int N = 4;
   localparam int W = `PKTW + 1;
   logic             clk;
   logic             rst;
   logic [N-1:0]     fifo_empty;
   logic [N*W-1:0]   fifo_out;
   logic [N-1:0]     fifo_re;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     grant;
`ifdef SW_ARB_CNT_EN
   logic             cnt_clr;
   logic [N*16-1:0]  grant_cnt;
`endif
   logic [W-1:0]     q [N][$];
   logic [N-1:0]     re_s;
   int               total;
   int               bad;

   sw_out_arb #(.NIN(N)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
      .fifo_re(fifo_re), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .grant(grant)
`ifdef SW_ARB_CNT_EN
      , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = (q[i].size() == 0);
         fifo_out[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
      end
   endtask

   // one clock: pop whatever the DUT popped, refresh FIFO heads, land at posedge+2
   task automatic step();
      re_s = fifo_re;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (re_s[i]) begin
            total++;
            if (q[i].size() == 0) begin
               bad++;
               $display("FAIL pop_empty fifo=%0d popped while empty", i);
            end else begin
               void'(q[i].pop_front());
            end
         end
      end
      #1;
      drive();
      #1;
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) q[i].delete();
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      clear_q();
      drive();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      clear_q();
      drive();
      #1;
      rst = 1'b0;
      q[0].push_back(W'(32'h55));
      drive();
      #2;
      total++; if (fifo_re !== 4'b0000) begin bad++; $display("FAIL reset_re got=%b want=0000", fifo_re); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
      reset_dut();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      q[2].push_back(W'(32'hA));
      q[2].push_back(W'(32'hB));
      drive();
      #1;
      total++; if (fifo_re !== 4'b0100) begin bad++; $display("FAIL single_re0 got=%b want=0100", fifo_re); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== W'(32'hA) || grant !== 4'b0100) begin
         bad++; $display("FAIL single_a got=%b/%h/%b want=1/a/0100", out_valid, out_data, grant); end
      total++; if (fifo_re !== 4'b0100) begin bad++; $display("FAIL single_re1 got=%b want=0100", fifo_re); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== W'(32'hB) || grant !== 4'b0100) begin
         bad++; $display("FAIL single_b got=%b/%h/%b want=1/b/0100", out_valid, out_data, grant); end
      total++; if (fifo_re !== 4'b0000) begin bad++; $display("FAIL single_re2 got=%b want=0000", fifo_re); end
      step();
      total++; if (out_valid !== 1'b0 || out_data !== W'(32'hB) || grant !== 4'b0100) begin
         bad++; $display("FAIL single_drop got=%b/%h/%b want=0/b/0100", out_valid, out_data, grant); end
   endtask

   task automatic test_round_robin();
      reset_dut();
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < N; i++) q[i].push_back(W'(256*i + j));
      drive();
      #1;
      for (int k = 0; k < 12; k++) begin
         total++; if (fifo_re !== N'(1 << (k % N))) begin
            bad++; $display("FAIL rr_re k=%0d got=%b want=%b", k, fifo_re, N'(1 << (k % N))); end
         step();
         total++; if (out_valid !== 1'b1 || grant !== N'(1 << (k % N)) || out_data !== W'(256*(k % N) + k / N)) begin
            bad++; $display("FAIL rr_word k=%0d got=%b/%b/%h want=1/%b/%h", k, out_valid, grant, out_data,
                            N'(1 << (k % N)), W'(256*(k % N) + k / N)); end
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_end got=%b want=0", out_valid); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      q[0].push_back(W'(32'hC0));
      q[0].push_back(W'(32'hC1));
      drive();
      #1;
      step();
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         total++; if (fifo_re !== 4'b0000) begin bad++; $display("FAIL stall_re k=%0d got=%b want=0000", k, fifo_re); end
         step();
         total++; if (out_valid !== 1'b1 || out_data !== W'(32'hC0)) begin
            bad++; $display("FAIL stall_hold k=%0d got=%b/%h want=1/c0", k, out_valid, out_data); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (fifo_re !== 4'b0001) begin bad++; $display("FAIL stall_release_re got=%b want=0001", fifo_re); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== W'(32'hC1)) begin
         bad++; $display("FAIL stall_next got=%b/%h want=1/c1", out_valid, out_data); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_end got=%b want=0", out_valid); end
   endtask

   task automatic test_skip_empty();
      out_ready = 1'b1;
      q[1].push_back(W'(32'hD1));
      for (int j = 0; j < 3; j++) q[3].push_back(W'(32'hE0 + j));
      drive();
      #1;
      total++; if (fifo_re !== 4'b0010) begin bad++; $display("FAIL skip_re0 got=%b want=0010", fifo_re); end
      step();
      total++; if (grant !== 4'b0010 || out_data !== W'(32'hD1)) begin
         bad++; $display("FAIL skip_p got=%b/%h want=0010/d1", grant, out_data); end
      for (int j = 0; j < 3; j++) begin
         total++; if (fifo_re !== 4'b1000) begin bad++; $display("FAIL skip_re j=%0d got=%b want=1000", j, fifo_re); end
         step();
         total++; if (out_valid !== 1'b1 || grant !== 4'b1000 || out_data !== W'(32'hE0 + j)) begin
            bad++; $display("FAIL skip_s j=%0d got=%b/%b/%h want=1/1000/%h", j, out_valid, grant, out_data, W'(32'hE0 + j)); end
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skip_end got=%b want=0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) q[2].push_back(W'(32'hF0 + j));
      drive();
      #1;
      step();
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_data !== '0) begin
         bad++; $display("FAIL areset_out got=%b/%h want=0/0", out_valid, out_data); end
      total++; if (fifo_re !== 4'b0000) begin bad++; $display("FAIL areset_re got=%b want=0000", fifo_re); end
      clear_q();
      drive();
      #1;
      rst = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      q[0].push_back(W'(32'h99));
      q[2].push_back(W'(32'h77));
      drive();
      #1;
      total++; if (fifo_re !== 4'b0001) begin bad++; $display("FAIL areset_first_re got=%b want=0001", fifo_re); end
      step();
      total++; if (grant !== 4'b0001 || out_data !== W'(32'h99)) begin
         bad++; $display("FAIL areset_first got=%b/%h want=0001/99", grant, out_data); end
      step();
      step();
   endtask

`ifdef SW_ARB_CNT_EN
   task automatic test_counters();
      reset_dut();
      cnt_clr = 1'b0;
      out_ready = 1'b1;
      fifo_empty = 4'b1110;
      #1;
      repeat (70000) @(posedge clk);
      #1;
      total++; if (grant_cnt[15:0] !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h want=ffff", grant_cnt[15:0]); end
      total++; if (grant_cnt[63:16] !== 48'h0) begin bad++; $display("FAIL cnt_others got=%h want=0", grant_cnt[63:16]); end
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      fifo_empty = 4'b1111;
      total++; if (grant_cnt[15:0] !== 16'h0) begin bad++; $display("FAIL cnt_clr got=%h want=0", grant_cnt[15:0]); end
      reset_dut();
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      re_s = '0;
      out_ready = 1'b0;
`ifdef SW_ARB_CNT_EN
      cnt_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_skip_empty();
      test_async_reset();
`ifdef SW_ARB_CNT_EN
      test_counters();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
